// File: rtl/div_radix4_hs_pkg.sv
// Shared definitions for the radix-4 iterative divider.
//
// Contents:
//   state_t       FSM state encoding (IDLE / BUSY / DONE)
//   DIGIT_0..3    quotient digit encodings produced by one radix-4 step
//   calcIter()    worst-case iteration count for a given operand width
//
// Optional build macro used by the divider top: DIV_EARLY_OUT_EN
package div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [1:0] DIGIT_0 = 2'd0;
    localparam logic [1:0] DIGIT_1 = 2'd1;
    localparam logic [1:0] DIGIT_2 = 2'd2;
    localparam logic [1:0] DIGIT_3 = 2'd3;

    // Two quotient bits retire per step, so an N-bit quotient needs N/2 steps.
    function automatic int calcIter(input int width);
        return width / 2;
    endfunction

endpackage

// File: rtl/div_radix4_hs_step.sv
// One radix-4 restoring division step (purely combinational).
//
// Ports:
//   i_x      partial remainder (2*WIDTH bits)
//   i_d1     divisor x1, aligned to the current digit position
//   i_d2     divisor x2, same alignment
//   i_d3     divisor x3, same alignment
//   o_x      partial remainder after subtracting the chosen multiple
//   o_digit  quotient digit (0..3) retired by this step
module div_r4_step
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] i_x,
    input  logic [2*WIDTH-1:0] i_d1,
    input  logic [2*WIDTH-1:0] i_d2,
    input  logic [2*WIDTH-1:0] i_d3,
    output logic [2*WIDTH-1:0] o_x,
    output logic [1:0]         o_digit
);

    localparam int XW = 2 * WIDTH;

    logic [XW:0] w_s1;
    logic [XW:0] w_s2;
    logic [XW:0] w_s3;

    // Three trial subtractions with one extra bit so the MSB is the borrow.
    // The largest multiple that still leaves a non-negative remainder wins.
    always_comb begin
        w_s3    = {1'b0, i_x} - {1'b0, i_d3};
        w_s2    = {1'b0, i_x} - {1'b0, i_d2};
        w_s1    = {1'b0, i_x} - {1'b0, i_d1};
        o_x     = i_x;
        o_digit = DIGIT_0;
        if (!w_s3[XW]) begin
            o_x     = w_s3[XW-1:0];
            o_digit = DIGIT_3;
        end else if (!w_s2[XW]) begin
            o_x     = w_s2[XW-1:0];
            o_digit = DIGIT_2;
        end else if (!w_s1[XW]) begin
            o_x     = w_s1[XW-1:0];
            o_digit = DIGIT_1;
        end
    end

endmodule

// File: rtl/div_radix4_hs.sv
// Iterative radix-4 integer divider with valid/ready handshakes and cancel.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   in_valid / in_ready    request handshake; sign, a, b sampled on accept
//   cancel                 aborts any operation, discards a pending result
//   out_valid / out_ready  response handshake; q, r, div_by_zero held in DONE
//   busy                   high while iterating
//
// Build option:
//   DIV_EARLY_OUT_EN  when defined, the iteration count is trimmed to the
//                     significant length of |a| (leading-zero count); results
//                     are identical, only latency changes.
module div_radix4_hs
    import div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             div_by_zero,
    output logic             busy
);

    localparam int ITER  = calcIter(WIDTH);
    localparam int XW    = 2 * WIDTH;
    localparam int CNT_W = $clog2(ITER) + 1;

    state_t           r_state;
    state_t           w_nextState;
    logic             w_accept;
    logic             w_zeroPath;
    logic             w_stepLast;
    logic [WIDTH-1:0] w_aMag;
    logic [WIDTH-1:0] w_bMag;
    logic [XW-1:0]    w_d1Init;
    logic [XW-1:0]    w_stepX;
    logic [1:0]       w_digit;
    logic [CNT_W-1:0] w_lastCnt;

    logic [XW-1:0]    r_x;
    logic [XW-1:0]    r_d1;
    logic [XW-1:0]    r_d2;
    logic [XW-1:0]    r_d3;
    logic [WIDTH-1:0] r_quot;
    logic [CNT_W-1:0] r_cnt;
    logic             r_signQ;
    logic             r_signR;
    logic             r_dbz;

    // Unsigned magnitudes; MIN negates to itself, which reads correctly as
    // 2^(WIDTH-1) in the unsigned datapath.
    always_comb begin
        w_aMag = (sign && a[WIDTH-1]) ? -a : a;
        w_bMag = (sign && b[WIDTH-1]) ? -b : b;
    end

`ifdef DIV_EARLY_OUT_EN
    localparam int LEN_W = $clog2(WIDTH + 1);
    localparam int SH_W  = $clog2(XW);

    logic [LEN_W-1:0] w_bitLen;
    logic [CNT_W-1:0] w_k;
    logic [SH_W-1:0]  w_shamt;
    logic [CNT_W-1:0] r_lastCnt;

    // Leading-zero scan of |a| gives the number of radix-4 digits actually
    // needed; the divisor is aligned to the top of that shorter quotient.
    always_comb begin
        w_bitLen = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (w_aMag[i]) begin
                w_bitLen = LEN_W'(i + 1);
            end
        end
        w_k        = CNT_W'((int'(w_bitLen) + 1) / 2);
        w_shamt    = (w_k == '0) ? '0 : SH_W'(2 * (int'(w_k) - 1));
        w_d1Init   = {{WIDTH{1'b0}}, w_bMag} << w_shamt;
        w_zeroPath = (b == '0) || (w_k == '0);
        w_lastCnt  = r_lastCnt;
    end
`else
    localparam int FULL_SHIFT = 2 * (ITER - 1);

    // Fixed-length divide: divisor aligned to the top digit of a full quotient.
    always_comb begin
        w_d1Init   = {{WIDTH{1'b0}}, w_bMag} << FULL_SHIFT;
        w_zeroPath = (b == '0);
        w_lastCnt  = CNT_W'(ITER - 1);
    end
`endif

    div_r4_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_x     (r_x),
        .i_d1    (r_d1),
        .i_d2    (r_d2),
        .i_d3    (r_d3),
        .o_x     (w_stepX),
        .o_digit (w_digit)
    );

    // Handshake decode and next-state logic. Cancel dominates everything,
    // and a consumed result may be replaced by a new request on the same edge.
    always_comb begin
        w_nextState = r_state;
        in_ready    = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
        w_accept    = in_valid && in_ready && !cancel;
        w_stepLast  = (r_cnt == w_lastCnt);
        out_valid   = (r_state == ST_DONE);
        busy        = (r_state == ST_BUSY);
        if (cancel) begin
            w_nextState = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_nextState = w_zeroPath ? ST_DONE : ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (w_stepLast) begin
                        w_nextState = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        if (w_accept) begin
                            w_nextState = w_zeroPath ? ST_DONE : ST_BUSY;
                        end else begin
                            w_nextState = ST_IDLE;
                        end
                    end
                end
                default: w_nextState = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Datapath: load operands on accept, then retire one digit per BUSY cycle.
    // A zero divisor preloads the defined all-ones/raw-dividend result with
    // sign fixup disabled so the DONE outputs come straight from the registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_x     <= '0;
            r_d1    <= '0;
            r_d2    <= '0;
            r_d3    <= '0;
            r_quot  <= '0;
            r_cnt   <= '0;
            r_signQ <= 1'b0;
            r_signR <= 1'b0;
            r_dbz   <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
            r_lastCnt <= '0;
`endif
        end else if (w_accept) begin
            r_cnt <= '0;
            r_d1  <= w_d1Init;
            r_d2  <= w_d1Init << 1;
            r_d3  <= w_d1Init + (w_d1Init << 1);
`ifdef DIV_EARLY_OUT_EN
            r_lastCnt <= w_k - 1'b1;
`endif
            if (b == '0) begin
                r_x     <= {{WIDTH{1'b0}}, a};
                r_quot  <= '1;
                r_signQ <= 1'b0;
                r_signR <= 1'b0;
                r_dbz   <= 1'b1;
            end else begin
                r_x     <= {{WIDTH{1'b0}}, w_aMag};
                r_quot  <= '0;
                r_signQ <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                r_signR <= sign & a[WIDTH-1];
                r_dbz   <= 1'b0;
            end
        end else if ((r_state == ST_BUSY) && !cancel) begin
            r_x    <= w_stepX;
            r_quot <= {r_quot[WIDTH-3:0], w_digit};
            r_d1   <= r_d1 >> 2;
            r_d2   <= r_d2 >> 2;
            r_d3   <= r_d3 >> 2;
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    // Sign fixup: quotient negative when operand signs differ, remainder
    // takes the dividend's sign (truncating division).
    always_comb begin
        q           = r_signQ ? -r_quot : r_quot;
        r           = r_signR ? -r_x[WIDTH-1:0] : r_x[WIDTH-1:0];
        div_by_zero = r_dbz;
    end

endmodule
